// File: rtl/ysyx_22040895_exe_mem_stage.sv
// Execute-to-memory stage: final result selection, branch/jump resolution and
// a two-entry skid buffer toward the memory stage, plus a registered redirect pulse.
module ysyx_22040895_exe_mem_stage #(
  parameter int XLEN          = 64,
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            lt_i,
  input  logic            ltu_i,
  input  logic            zero_i,
  input  logic            wordop_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rd_i,
  input  logic            rd_wen_i,
  input  logic            mem_ren_i,
  input  logic            mem_wen_i,
  input  logic [1:0]      mem_size_i,
  input  logic            mem_unsigned_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            rd_wen_o,
  output logic            mem_ren_o,
  output logic            mem_wen_o,
  output logic [1:0]      mem_size_o,
  output logic            mem_unsigned_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            rd_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
  } pkt_t;

  localparam int PKT_W = $bits(pkt_t);
  localparam logic [PKT_W-1:0] PKT_RST = RESET_PC_ZERO ? {PKT_W{1'b0}} : {PKT_W{1'b1}};
  localparam logic [XLEN-1:0] X_RST = RESET_PC_ZERO ? {XLEN{1'b0}} : {XLEN{1'b1}};
  localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0] LSB_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};

  // Handshake: a packet moves on a cycle where valid and ready are both high at
  // the rising edge; flush vetoes the input side. valid_o never drops and packet
  // fields never change while the memory stage holds ready_i low.
  state_e state, state_next;
  logic   ready_q;
  pkt_t   main_q, skid_q, incoming;
  logic   in_acc, out_acc;
  logic   load_main, load_skid, promote;
  logic   br_taken, take;
  logic   redirect_q;
  logic [XLEN-1:0] redirect_pc_q, target, word_ext;

  assign in_acc  = valid_i & ready_q & ~flush_i;
  assign out_acc = valid_o & ready_i;

  assign word_ext = {{(XLEN-32){alu_result_i[31]}}, alu_result_i[31:0]};

  always_comb begin
    incoming              = '0;
    incoming.rd           = rd_i;
    incoming.rd_wen       = rd_wen_i;
    incoming.mem_ren      = mem_ren_i;
    incoming.mem_wen      = mem_wen_i;
    incoming.mem_size     = mem_size_i;
    incoming.mem_unsigned = mem_unsigned_i;
    incoming.store_data   = store_data_i;
    incoming.pc           = pc_i;
    if (is_jal_i || is_jalr_i) incoming.result = pc_i + FOUR;
    else if (wordop_i)         incoming.result = word_ext;
    else                       incoming.result = alu_result_i;
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3_i)
      3'b000:  br_taken = zero_i;
      3'b001:  br_taken = ~zero_i;
      3'b100:  br_taken = lt_i;
      3'b101:  br_taken = ~lt_i;
      3'b110:  br_taken = ltu_i;
      3'b111:  br_taken = ~ltu_i;
      default: br_taken = 1'b0;
    endcase
  end

  assign take   = (is_branch_i & br_taken) | is_jal_i | is_jalr_i;
  // The ALU already formed rs1 + imm for jalr; only bit 0 needs clearing.
  assign target = is_jalr_i ? (alu_result_i & LSB_CLR) : (pc_i + imm_i);

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    promote    = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_acc) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
        ONE: begin
          if (in_acc && out_acc) begin
            load_main = 1'b1;
          end else if (in_acc) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (out_acc) begin
            state_next = EMPTY;
          end
        end
        FULL: if (out_acc) begin
          state_next = ONE;
          promote    = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= pkt_t'(PKT_RST);
      skid_q  <= pkt_t'(PKT_RST);
    end else begin
      state   <= state_next;
      ready_q <= (state_next != FULL);
      if (load_main)    main_q <= incoming;
      else if (promote) main_q <= skid_q;
      if (load_skid)    skid_q <= incoming;
    end
  end

  // Redirect follows the in-accept, not the output side, so it fires even when
  // the packet lands in the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= X_RST;
    end else begin
      redirect_q <= in_acc & take;
      if (in_acc && take) redirect_pc_q <= target;
    end
  end

  assign ready_o        = ready_q;
  assign valid_o        = (state != EMPTY);
  assign result_o       = main_q.result;
  assign rd_o           = main_q.rd;
  assign rd_wen_o       = main_q.rd_wen;
  assign mem_ren_o      = main_q.mem_ren;
  assign mem_wen_o      = main_q.mem_wen;
  assign mem_size_o     = main_q.mem_size;
  assign mem_unsigned_o = main_q.mem_unsigned;
  assign store_data_o   = main_q.store_data;
  assign pc_o           = main_q.pc;
  assign redirect_o     = redirect_q;
  assign redirect_pc_o  = redirect_pc_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_ysyx_22040895_exe_mem_stage.sv
// Bench for the execute-to-memory stage: directed scenarios plus a random run
// against a queue-based reference model of the stage.
module tb_ysyx_22040895_exe_mem_stage;

  typedef struct packed {
    logic [63:0] alu;
    logic        lt, ltu, zero, wordop, br, jal, jalr;
    logic [2:0]  f3;
    logic [63:0] pc, imm;
    logic [4:0]  rd;
    logic        rd_wen, mren, mwen;
    logic [1:0]  msize;
    logic        muns;
    logic [63:0] sd;
  } pkt_t;

  localparam int OUT_W = 64 + 5 + 1 + 1 + 1 + 2 + 1 + 64 + 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, valid = 1'b0, ready = 1'b0;
  pkt_t cur = '0;

  logic        ready_o, valid_o, rd_wen_o, mem_ren_o, mem_wen_o, mem_unsigned_o, redirect_o;
  logic [63:0] result_o, store_data_o, pc_o, redirect_pc_o;
  logic [4:0]  rd_o;
  logic [1:0]  mem_size_o, fsm_state;
  logic [OUT_W-1:0] act;

  logic [OUT_W-1:0] exp_q[$];
  logic        exp_redir = 1'b0;
  logic [63:0] exp_redir_pc = '0;
  int n_checks = 0;
  int n_fail = 0;

  ysyx_22040895_exe_mem_stage #(.XLEN(64), .RESET_PC_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready_o),
    .alu_result_i(cur.alu), .lt_i(cur.lt), .ltu_i(cur.ltu), .zero_i(cur.zero),
    .wordop_i(cur.wordop), .is_branch_i(cur.br), .is_jal_i(cur.jal), .is_jalr_i(cur.jalr),
    .funct3_i(cur.f3), .pc_i(cur.pc), .imm_i(cur.imm), .rd_i(cur.rd), .rd_wen_i(cur.rd_wen),
    .mem_ren_i(cur.mren), .mem_wen_i(cur.mwen), .mem_size_i(cur.msize),
    .mem_unsigned_i(cur.muns), .store_data_i(cur.sd),
    .valid_o(valid_o), .ready_i(ready), .result_o(result_o), .rd_o(rd_o),
    .rd_wen_o(rd_wen_o), .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o),
    .mem_size_o(mem_size_o), .mem_unsigned_o(mem_unsigned_o), .store_data_o(store_data_o),
    .pc_o(pc_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .fsm_state(fsm_state)
  );

  assign act = {result_o, rd_o, rd_wen_o, mem_ren_o, mem_wen_o, mem_size_o,
                mem_unsigned_o, store_data_o, pc_o};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(pkt_t p);
    if (p.jal || p.jalr) return p.pc + 64'd4;
    if (p.wordop) return p.alu[31] ? {32'hFFFF_FFFF, p.alu[31:0]} : {32'h0, p.alu[31:0]};
    return p.alu;
  endfunction

  function automatic logic ref_taken(pkt_t p);
    logic t;
    case (p.f3)
      3'b000:  t = p.zero;
      3'b001:  t = !p.zero;
      3'b100:  t = p.lt;
      3'b101:  t = !p.lt;
      3'b110:  t = p.ltu;
      3'b111:  t = !p.ltu;
      default: t = 1'b0;
    endcase
    return (p.br && t) || p.jal || p.jalr;
  endfunction

  function automatic logic [63:0] ref_target(pkt_t p);
    if (p.jalr) return {p.alu[63:1], 1'b0};
    return p.pc + p.imm;
  endfunction

  function automatic logic [OUT_W-1:0] ref_out(pkt_t p);
    return {ref_result(p), p.rd, p.rd_wen, p.mren, p.mwen, p.msize, p.muns, p.sd, p.pc};
  endfunction

  function automatic pkt_t quiet_pkt();
    pkt_t p;
    p.alu = {$urandom, $urandom}; p.pc = {$urandom, $urandom}; p.imm = {$urandom, $urandom};
    p.sd = {$urandom, $urandom}; p.rd = 5'($urandom); p.f3 = 3'($urandom);
    p.msize = 2'($urandom); p.rd_wen = 1'($urandom); p.mren = 1'($urandom);
    p.mwen = 1'($urandom); p.muns = 1'($urandom); p.lt = 1'($urandom);
    p.ltu = 1'($urandom); p.zero = 1'($urandom);
    p.wordop = 1'b0; p.br = 1'b0; p.jal = 1'b0; p.jalr = 1'b0;
    return p;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    int kind;
    p = quiet_pkt();
    kind = $urandom_range(0, 4);
    p.br     = (kind == 1);
    p.jal    = (kind == 2);
    p.jalr   = (kind == 3);
    p.wordop = (kind == 4) || ((kind == 0) && ($urandom_range(0, 1) == 1));
    return p;
  endfunction

  // ---------------- driver: advance one clock with the model ----------------
  task automatic tick();
    logic in_acc, out_acc;
    in_acc  = valid && !flush && (exp_q.size() < 2);
    out_acc = (exp_q.size() > 0) && ready;
    if (flush) begin
      exp_q.delete();
      exp_redir = 1'b0;
    end else begin
      if (out_acc) void'(exp_q.pop_front());
      if (in_acc) exp_q.push_back(ref_out(cur));
      exp_redir = in_acc && ref_taken(cur);
      if (exp_redir) exp_redir_pc = ref_target(cur);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    valid = 1'b0; flush = 1'b0; ready = 1'b1;
    repeat (3) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%b exp=0", redirect_o); end
    n_checks++; if (act !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", act); end
    n_checks++; if (redirect_pc_o !== 64'h0) begin n_fail++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wordop();
    drain();
    cur = quiet_pkt(); cur.alu = 64'h0000_0000_8000_0001; cur.wordop = 1'b1;
    valid = 1'b1; ready = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL wordop_valid got=%b exp=1", valid_o); end
    n_checks++; if (result_o !== 64'hFFFF_FFFF_8000_0001) begin n_fail++; $display("FAIL wordop_result got=%h exp=ffffffff80000001", result_o); end
    n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL wordop_redirect got=%b exp=0", redirect_o); end
    tick();
  endtask

  task automatic test_branch();
    drain();
    cur = quiet_pkt(); cur.br = 1'b1; cur.f3 = 3'b100; cur.lt = 1'b1;
    cur.pc = 64'h8000_0000; cur.imm = 64'h10;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL blt_taken_pulse got=%b exp=1", redirect_o); end
    n_checks++; if (redirect_pc_o !== 64'h8000_0010) begin n_fail++; $display("FAIL blt_target got=%h exp=80000010", redirect_pc_o); end
    tick();
    n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL blt_pulse_width got=%b exp=0", redirect_o); end
    cur.lt = 1'b0; cur.imm = 64'h40;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL blt_not_taken got=%b exp=0", redirect_o); end
    n_checks++; if (redirect_pc_o !== 64'h8000_0010) begin n_fail++; $display("FAIL redirect_pc_hold got=%h exp=80000010", redirect_pc_o); end
    tick();
  endtask

  task automatic test_jalr();
    drain();
    cur = quiet_pkt(); cur.jalr = 1'b1; cur.alu = 64'h8000_1235; cur.pc = 64'h8000_0100;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL jalr_pulse got=%b exp=1", redirect_o); end
    n_checks++; if (redirect_pc_o !== 64'h8000_1234) begin n_fail++; $display("FAIL jalr_target got=%h exp=80001234", redirect_pc_o); end
    n_checks++; if (result_o !== 64'h8000_0104) begin n_fail++; $display("FAIL jalr_link got=%h exp=80000104", result_o); end
    tick();
  endtask

  task automatic test_backpressure();
    pkt_t pa, pb, pc;
    drain();
    pa = quiet_pkt(); pb = quiet_pkt(); pc = quiet_pkt();
    ready = 1'b0;
    cur = pa; valid = 1'b1; tick();
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_a got=%b exp=1", ready_o); end
    cur = pb; tick();
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got=%b exp=0", ready_o); end
    cur = pc; tick();
    n_checks++; if (result_o !== pa.alu) begin n_fail++; $display("FAIL bp_hold_a got=%h exp=%h", result_o, pa.alu); end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_c_held got=%b exp=0", ready_o); end
    ready = 1'b1; tick();
    n_checks++; if (result_o !== pb.alu) begin n_fail++; $display("FAIL bp_order_b got=%h exp=%h", result_o, pb.alu); end
    tick();
    valid = 1'b0;
    n_checks++; if (result_o !== pc.alu || valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_order_c got=%h/%b exp=%h/1", result_o, valid_o, pc.alu); end
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%b exp=0", valid_o); end
  endtask

  task automatic test_back_to_back();
    pkt_t p;
    drain();
    for (int i = 0; i < 8; i++) begin
      p = rand_pkt();
      cur = p; valid = 1'b1;
      tick();
      n_checks++;
      if (act !== ref_out(p) || valid_o !== 1'b1) begin
        n_fail++; $display("FAIL b2b_pkt%0d got=%h exp=%h", i, act, ref_out(p));
      end
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_full();
    drain();
    ready = 1'b0;
    cur = quiet_pkt(); valid = 1'b1; tick();
    cur = quiet_pkt(); tick();
    cur = quiet_pkt(); cur.jal = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
    n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL flush_redirect got=%b exp=0", redirect_o); end
    ready = 1'b1;
    tick(); tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_jal_leak got=%b exp=0", valid_o); end
  endtask

  task automatic test_async_reset();
    drain();
    ready = 1'b0;
    cur = quiet_pkt(); valid = 1'b1; tick();
    cur = quiet_pkt(); cur.jal = 1'b1; tick();
    valid = 1'b0;
    n_checks++; if (ready_o !== 1'b0 || redirect_o !== 1'b1) begin n_fail++; $display("FAIL areset_setup got=%b/%b exp=0/1", ready_o, redirect_o); end
    #2; rst = 1'b1; #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", valid_o); end
    n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL areset_redirect got=%b exp=0", redirect_o); end
    n_checks++; if (result_o !== 64'h0) begin n_fail++; $display("FAIL areset_result got=%h exp=0", result_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL areset_ready got=%b exp=1", ready_o); end
    #2; rst = 1'b0;
    exp_q.delete(); exp_redir = 1'b0; exp_redir_pc = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cur   = rand_pkt();
      valid = ($urandom_range(0, 9) < 7);
      ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      tick();
      n_checks++;
      if (valid_o !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, valid_o, exp_q.size() > 0); end
      n_checks++;
      if (ready_o !== (exp_q.size() < 2)) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, ready_o, exp_q.size() < 2); end
      n_checks++;
      if (redirect_o !== exp_redir) begin n_fail++; $display("FAIL rand_redirect cyc=%0d got=%b exp=%b", c, redirect_o, exp_redir); end
      n_checks++;
      if (redirect_pc_o !== exp_redir_pc) begin n_fail++; $display("FAIL rand_redirect_pc cyc=%0d got=%h exp=%h", c, redirect_pc_o, exp_redir_pc); end
      if (exp_q.size() > 0) begin
        n_checks++;
        if (act !== exp_q[0]) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, act, exp_q[0]); end
      end
    end
    flush = 1'b0;
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_wordop();
    test_branch();
    test_jalr();
    test_backpressure();
    test_back_to_back();
    test_flush_full();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
